// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response handshake plus data-memory port of the
// MEM-stage load/store initiator, bundled so both ends share one definition.
interface mem_access_unit_if #(
   parameter int ADDR_W = 18
);
   // pipeline request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_MemOp;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   // pipeline response and stall
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              busy;
   // data-memory port
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [2:0]        mem_MemOp;
   logic [31:0]       mem_datain;
   logic [31:0]       mem_dataout;

   // the access unit itself
   modport slave (
      input  req_valid, req_we, req_MemOp, req_addr, req_wdata, mem_dataout,
      output req_ready, resp_valid, resp_rdata, resp_err, busy,
             mem_addr, mem_we, mem_MemOp, mem_datain
   );

   // pipeline + memory side driving the unit
   modport master (
      output req_valid, req_we, req_MemOp, req_addr, req_wdata, mem_dataout,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy,
             mem_addr, mem_we, mem_MemOp, mem_datain
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Takes one request at a time, runs each
// memory beat as SETUP (address only) then XFER (write strobe / read sample),
// splits misaligned h/w accesses into byte beats and assembles load data.
module mem_access_unit #(
   parameter int ADDR_W           = 18,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic clk,
   input  logic rst,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_r;
   logic              we_r;
   logic [2:0]        op_r;
   logic [2:0]        code_r;
   logic              split_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic [31:0]       asm_r;
   logic [1:0]        k_r;
   logic [1:0]        last_r;

   logic              ready_r;
   logic              busy_r;
   logic              resp_valid_r;
   logic [31:0]       resp_rdata_r;
   logic              resp_err_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_we_r;
   logic [2:0]        mem_op_r;
   logic [31:0]       mem_datain_r;

   logic              hi_bad_s;
   logic              op_bad_s;
   logic              mis_s;
   logic              acc_err_s;
   logic [2:0]        acc_code_s;
   logic [1:0]        acc_last_s;
   logic [31:0]       acc_datain_s;

   logic [1:0]        k_nxt_s;
   logic [ADDR_W-1:0] nxt_addr_s;
   logic [31:0]       nxt_datain_s;
   logic [31:0]       asm_s;
   logic [31:0]       ld_s;

   // Decode the incoming request: legality, alignment and first-beat plan.
   always_comb begin
      hi_bad_s = |bus.req_addr[31:ADDR_W];
      case (bus.req_MemOp)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_bad_s = 1'b0;
         default:                                op_bad_s = 1'b1;
      endcase
      case (bus.req_MemOp[1:0])
         2'b01:   mis_s = bus.req_addr[0];
         2'b10:   mis_s = |bus.req_addr[1:0];
         default: mis_s = 1'b0;
      endcase
      acc_err_s = hi_bad_s | op_bad_s | (mis_s & (SPLIT_MISALIGNED == 1'b0));
      // byte beats: lbu-style read, sb-style write; stores never carry bit 2
      if (mis_s) begin
         acc_code_s = bus.req_we ? 3'b000 : 3'b100;
      end else if (bus.req_we) begin
         acc_code_s = {1'b0, bus.req_MemOp[1:0]};
      end else begin
         acc_code_s = bus.req_MemOp;
      end
      if (!mis_s) begin
         acc_last_s = 2'd0;
      end else if (bus.req_MemOp[1:0] == 2'b10) begin
         acc_last_s = 2'd3;
      end else begin
         acc_last_s = 2'd1;
      end
      if (!bus.req_we) begin
         acc_datain_s = 32'h0000_0000;
      end else if (mis_s) begin
         acc_datain_s = {24'h00_0000, bus.req_wdata[7:0]};
      end else begin
         acc_datain_s = bus.req_wdata;
      end
   end

   // Next-beat address/data and load assembly/extension for the current beat.
   always_comb begin
      k_nxt_s    = k_r + 2'd1;
      nxt_addr_s = addr_r + {{(ADDR_W-2){1'b0}}, k_nxt_s};
      if (we_r) begin
         nxt_datain_s = {24'h00_0000, wdata_r[{k_nxt_s, 3'b000} +: 8]};
      end else begin
         nxt_datain_s = 32'h0000_0000;
      end
      asm_s = asm_r;
      asm_s[{k_r, 3'b000} +: 8] = bus.mem_dataout[7:0];
      if (!split_r) begin
         // single aligned beat: memory has already extended the value
         ld_s = bus.mem_dataout;
      end else begin
         case (op_r)
            3'b001:  ld_s = {{16{asm_s[15]}}, asm_s[15:0]};
            3'b101:  ld_s = {16'h0000, asm_s[15:0]};
            default: ld_s = asm_s;
         endcase
      end
   end

   // Control FSM with all pipeline- and memory-facing outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         we_r         <= 1'b0;
         op_r         <= 3'b000;
         code_r       <= 3'b010;
         split_r      <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= 32'h0000_0000;
         asm_r        <= 32'h0000_0000;
         k_r          <= 2'd0;
         last_r       <= 2'd0;
         ready_r      <= 1'b1;
         busy_r       <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
         mem_addr_r   <= '0;
         mem_we_r     <= 1'b0;
         mem_op_r     <= 3'b010;
         mem_datain_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  we_r    <= bus.req_we;
                  op_r    <= bus.req_MemOp;
                  code_r  <= acc_code_s;
                  split_r <= mis_s;
                  addr_r  <= bus.req_addr[ADDR_W-1:0];
                  wdata_r <= bus.req_wdata;
                  asm_r   <= 32'h0000_0000;
                  k_r     <= 2'd0;
                  last_r  <= acc_last_s;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
                  if (acc_err_s) begin
                     state_r      <= DONE;
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b1;
                     resp_rdata_r <= 32'h0000_0000;
                  end else begin
                     state_r      <= SETUP;
                     mem_addr_r   <= bus.req_addr[ADDR_W-1:0];
                     mem_op_r     <= acc_code_s;
                     mem_datain_r <= acc_datain_s;
                  end
               end
            end
            SETUP: begin
               // address has been stable for a cycle; now strobe stores
               mem_we_r <= we_r;
               state_r  <= XFER;
            end
            XFER: begin
               mem_we_r <= 1'b0;
               asm_r    <= asm_s;
               if (k_r == last_r) begin
                  state_r      <= DONE;
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= 1'b0;
                  resp_rdata_r <= we_r ? 32'h0000_0000 : ld_s;
                  mem_addr_r   <= '0;
                  mem_op_r     <= 3'b010;
                  mem_datain_r <= 32'h0000_0000;
               end else begin
                  state_r      <= SETUP;
                  k_r          <= k_nxt_s;
                  mem_addr_r   <= nxt_addr_s;
                  mem_op_r     <= code_r;
                  mem_datain_r <= nxt_datain_s;
               end
            end
            DONE: begin
               state_r      <= IDLE;
               resp_valid_r <= 1'b0;
               resp_err_r   <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
               ready_r      <= 1'b1;
               busy_r       <= 1'b0;
            end
            default: begin
               state_r      <= IDLE;
               ready_r      <= 1'b1;
               busy_r       <= 1'b0;
               resp_valid_r <= 1'b0;
               mem_we_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready_r;
   assign bus.busy       = busy_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign bus.resp_err   = resp_err_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_MemOp  = mem_op_r;
   assign bus.mem_datain = mem_datain_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a byte-array data memory that writes on
// the falling edge and returns extended read data one cycle after the address.
module tb_mem_access_unit;

   logic clk;
   logic rst;
   int   chk_cnt;
   int   pass_cnt;

   mem_access_unit_if #(.ADDR_W(18)) bus ();
   mem_access_unit_if #(.ADDR_W(18)) bus2 ();

   mem_access_unit #(.ADDR_W(18), .SPLIT_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   mem_access_unit #(.ADDR_W(18), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   assign bus2.mem_dataout = 32'h0000_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [0:262143];

   function automatic logic [17:0] ap(input logic [17:0] a, input int i);
      return a + 18'(i);
   endfunction

   function automatic int nbytes(input logic [2:0] op);
      case (op[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] rd(input logic [17:0] a, input logic [2:0] op);
      logic [31:0] w;
      w = {mem[ap(a, 3)], mem[ap(a, 2)], mem[ap(a, 1)], mem[a]};
      case (op)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // memory write port commits on the falling edge
   always @(negedge clk) begin
      if (bus.mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (i < nbytes(bus.mem_MemOp)) mem[ap(bus.mem_addr, i)] <= bus.mem_datain[8*i +: 8];
         end
      end
   end

   // memory read port: data for the presented address the following cycle
   always @(posedge clk) bus.mem_dataout <= rd(bus.mem_addr, bus.mem_MemOp);

   logic [17:0] log_addr [0:31];
   logic [2:0]  log_op   [0:31];
   int          we_cnt;
   int          resp_cyc;
   logic [31:0] resp_data;
   logic        resp_e;

   task automatic poke32(input logic [17:0] a, input logic [31:0] v);
      for (int i = 0; i < 4; i++) mem[ap(a, i)] = v[8*i +: 8];
   endtask

   // Issue one request from IDLE and log the memory port cycle by cycle.
   task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_MemOp = op;
      bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      resp_cyc = 0; we_cnt = 0; resp_data = 32'h0; resp_e = 1'b0;
      for (int c = 1; c <= 20 && resp_cyc == 0; c++) begin
         @(negedge clk);
         log_addr[c] = bus.mem_addr;
         log_op[c]   = bus.mem_MemOp;
         if (bus.mem_we) we_cnt++;
         if (bus.resp_valid) begin
            resp_cyc = c; resp_data = bus.resp_rdata; resp_e = bus.resp_err;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if ({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err} !== 4'b1000)
         $display("FAIL reset_flags got=%b exp=1000", {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err});
      else pass_cnt++;
      chk_cnt++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_MemOp} !== {1'b0, 18'h0, 3'b010})
         $display("FAIL reset_mem got=%b/%h/%b exp=0/00000/010", bus.mem_we, bus.mem_addr, bus.mem_MemOp);
      else pass_cnt++;
      chk_cnt++;
      if ({bus.resp_rdata, bus.mem_datain} !== 64'h0)
         $display("FAIL reset_data got=%h/%h exp=0/0", bus.resp_rdata, bus.mem_datain);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_aligned_lw();
      poke32(18'h40, 32'h8899AABB);
      run_req(1'b0, 3'b010, 32'h40, 32'h0);
      chk_cnt++;
      if (resp_cyc !== 3) $display("FAIL alw_cycle got=%0d exp=3", resp_cyc); else pass_cnt++;
      chk_cnt++;
      if ({resp_e, resp_data} !== {1'b0, 32'h8899AABB})
         $display("FAIL alw_data got=%b/%h exp=0/8899aabb", resp_e, resp_data);
      else pass_cnt++;
      chk_cnt++;
      if ({we_cnt[3:0], log_addr[1], log_op[1], log_addr[2], log_op[2]} !== {4'd0, 18'h40, 3'b010, 18'h40, 3'b010})
         $display("FAIL alw_beat got=we%0d %h/%b %h/%b exp=we0 00040/010 twice", we_cnt, log_addr[1], log_op[1], log_addr[2], log_op[2]);
      else pass_cnt++;
   endtask

   task automatic test_byte_lane();
      run_req(1'b0, 3'b000, 32'h43, 32'h0);
      chk_cnt++;
      if (resp_data !== 32'hFFFFFF88) $display("FAIL lb got=%h exp=ffffff88", resp_data); else pass_cnt++;
      run_req(1'b0, 3'b100, 32'h43, 32'h0);
      chk_cnt++;
      if (resp_data !== 32'h00000088) $display("FAIL lbu got=%h exp=00000088", resp_data); else pass_cnt++;
      run_req(1'b1, 3'b000, 32'h41, 32'h5A);
      chk_cnt++;
      if ({resp_cyc[3:0], we_cnt[3:0], resp_data} !== {4'd3, 4'd1, 32'h0})
         $display("FAIL sb_resp got=c%0d we%0d %h exp=c3 we1 0", resp_cyc, we_cnt, resp_data);
      else pass_cnt++;
      run_req(1'b0, 3'b010, 32'h40, 32'h0);
      chk_cnt++;
      if (resp_data !== 32'h88995ABB) $display("FAIL sb_readback got=%h exp=88995abb", resp_data); else pass_cnt++;
      run_req(1'b1, 3'b100, 32'h42, 32'h77);
      chk_cnt++;
      if ({log_op[1], log_op[2]} !== {3'b000, 3'b000})
         $display("FAIL st_norm got=%b/%b exp=000/000", log_op[1], log_op[2]);
      else pass_cnt++;
      run_req(1'b0, 3'b010, 32'h40, 32'h0);
      chk_cnt++;
      if (resp_data !== 32'h88775ABB) $display("FAIL st_norm_rb got=%h exp=88775abb", resp_data); else pass_cnt++;
   endtask

   task automatic test_misaligned_lw();
      poke32(18'h40, 32'h44332211);
      poke32(18'h44, 32'h88776655);
      run_req(1'b0, 3'b010, 32'h42, 32'h0);
      chk_cnt++;
      if ({resp_cyc[3:0], resp_e, resp_data} !== {4'd9, 1'b0, 32'h66554433})
         $display("FAIL mlw_resp got=c%0d e%b %h exp=c9 e0 66554433", resp_cyc, resp_e, resp_data);
      else pass_cnt++;
      for (int b = 0; b < 4; b++) begin
         chk_cnt++;
         if ({log_addr[2*b+1], log_op[2*b+1], log_addr[2*b+2], log_op[2*b+2]} !== {ap(18'h42, b), 3'b100, ap(18'h42, b), 3'b100})
            $display("FAIL mlw_beat%0d got=%h/%b %h/%b exp=%h/100 held", b, log_addr[2*b+1], log_op[2*b+1], log_addr[2*b+2], log_op[2*b+2], ap(18'h42, b));
         else pass_cnt++;
      end
      chk_cnt++;
      if (we_cnt !== 0) $display("FAIL mlw_we got=%0d exp=0", we_cnt); else pass_cnt++;
   endtask

   task automatic test_misaligned_h();
      run_req(1'b1, 3'b001, 32'h47, 32'h0000BEEF);
      chk_cnt++;
      if ({resp_cyc[3:0], we_cnt[3:0], log_op[1], log_op[3]} !== {4'd5, 4'd2, 3'b000, 3'b000})
         $display("FAIL msh_resp got=c%0d we%0d %b/%b exp=c5 we2 000/000", resp_cyc, we_cnt, log_op[1], log_op[3]);
      else pass_cnt++;
      chk_cnt++;
      if ({mem[18'h47], mem[18'h48]} !== 16'hEFBE)
         $display("FAIL msh_mem got=%h%h exp=efbe", mem[18'h47], mem[18'h48]);
      else pass_cnt++;
      run_req(1'b0, 3'b001, 32'h47, 32'h0);
      chk_cnt++;
      if ({resp_cyc[3:0], resp_data} !== {4'd5, 32'hFFFFBEEF})
         $display("FAIL mlh got=c%0d %h exp=c5 ffffbeef", resp_cyc, resp_data);
      else pass_cnt++;
      run_req(1'b0, 3'b101, 32'h47, 32'h0);
      chk_cnt++;
      if (resp_data !== 32'h0000BEEF) $display("FAIL mlhu got=%h exp=0000beef", resp_data); else pass_cnt++;
      mem[18'h3FFFE] = 8'h01; mem[18'h3FFFF] = 8'h02; mem[18'h00000] = 8'h03; mem[18'h00001] = 8'h04;
      run_req(1'b0, 3'b010, 32'h3FFFE, 32'h0);
      chk_cnt++;
      if ({log_addr[1], log_addr[3], log_addr[5], log_addr[7]} !== {18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001})
         $display("FAIL wrap_addr got=%h %h %h %h exp=3fffe 3ffff 00000 00001", log_addr[1], log_addr[3], log_addr[5], log_addr[7]);
      else pass_cnt++;
      chk_cnt++;
      if (resp_data !== 32'h04030201) $display("FAIL wrap_data got=%h exp=04030201", resp_data); else pass_cnt++;
   endtask

   task automatic test_errors();
      run_req(1'b0, 3'b010, 32'h00040000, 32'h0);
      chk_cnt++;
      if ({resp_cyc[3:0], resp_e, we_cnt[3:0], resp_data} !== {4'd1, 1'b1, 4'd0, 32'h0})
         $display("FAIL err_range got=c%0d e%b we%0d %h exp=c1 e1 we0 0", resp_cyc, resp_e, we_cnt, resp_data);
      else pass_cnt++;
      run_req(1'b0, 3'b111, 32'h40, 32'h0);
      chk_cnt++;
      if ({resp_cyc[3:0], resp_e} !== {4'd1, 1'b1}) $display("FAIL err_ldop got=c%0d e%b exp=c1 e1", resp_cyc, resp_e); else pass_cnt++;
      run_req(1'b1, 3'b011, 32'h40, 32'h0);
      chk_cnt++;
      if ({resp_cyc[3:0], resp_e, we_cnt[3:0]} !== {4'd1, 1'b1, 4'd0})
         $display("FAIL err_stop got=c%0d e%b we%0d exp=c1 e1 we0", resp_cyc, resp_e, we_cnt);
      else pass_cnt++;
      // split disabled: misaligned lw must be refused
      @(negedge clk);
      bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_MemOp = 3'b010;
      bus2.req_addr = 32'h42; bus2.req_wdata = 32'h0;
      @(posedge clk);
      #1 bus2.req_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({bus2.resp_valid, bus2.resp_err, bus2.mem_we} !== 3'b110)
         $display("FAIL err_nosplit got=%b exp=110", {bus2.resp_valid, bus2.resp_err, bus2.mem_we});
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({bus2.resp_valid, bus2.req_ready} !== 2'b01)
         $display("FAIL err_nosplit_idle got=%b exp=01", {bus2.resp_valid, bus2.req_ready});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic seen;
      poke32(18'h50, 32'h0); poke32(18'h54, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_MemOp = 3'b010;
      bus.req_addr = 32'h51; bus.req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_cnt++;
      if ({bus.mem_we, bus.mem_addr} !== {1'b1, 18'h53})
         $display("FAIL rmid_pre got=%b/%h exp=1/00053", bus.mem_we, bus.mem_addr);
      else pass_cnt++;
      #1 rst = 1'b1;
      #1;
      chk_cnt++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_MemOp, bus.mem_datain, bus.req_ready, bus.busy, bus.resp_valid}
          !== {1'b0, 18'h0, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0})
         $display("FAIL rmid_async got=%b/%h/%b/%h/%b%b%b exp=0/00000/010/0/100", bus.mem_we, bus.mem_addr,
                  bus.mem_MemOp, bus.mem_datain, bus.req_ready, bus.busy, bus.resp_valid);
      else pass_cnt++;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.resp_valid) seen = 1'b1;
         if (c == 2) rst = 1'b0;
      end
      chk_cnt++;
      if (seen !== 1'b0) $display("FAIL rmid_noresp got=%b exp=0", seen); else pass_cnt++;
      chk_cnt++;
      if ({mem[18'h51], mem[18'h52], mem[18'h53]} !== 24'hD4C300)
         $display("FAIL rmid_partial got=%h%h%h exp=d4c300", mem[18'h51], mem[18'h52], mem[18'h53]);
      else pass_cnt++;
      run_req(1'b0, 3'b010, 32'h50, 32'h0);
      chk_cnt++;
      if ({resp_cyc[3:0], resp_data} !== {4'd3, 32'h00C3D400})
         $display("FAIL rmid_next got=c%0d %h exp=c3 00c3d400", resp_cyc, resp_data);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int          pulses;
      logic [12:0] rdy;
      logic [12:0] bsy;
      logic [12:0] rv;
      logic [31:0] last_data;
      poke32(18'h40, 32'h12345678);
      pulses = 0; rdy = '0; bsy = '0; rv = '0; last_data = 32'h0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_MemOp = 3'b010;
      bus.req_addr = 32'h40; bus.req_wdata = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         rdy[c] = bus.req_ready; bsy[c] = bus.busy; rv[c] = bus.resp_valid;
         if (bus.resp_valid) begin pulses++; last_data = bus.resp_rdata; end
         if (c == 12) bus.req_valid = 1'b0;
      end
      chk_cnt++;
      if (pulses !== 3) $display("FAIL b2b_count got=%0d exp=3", pulses); else pass_cnt++;
      chk_cnt++;
      if (rv[12:1] !== 12'b010001000100) $display("FAIL b2b_resp got=%b exp=010001000100", rv[12:1]); else pass_cnt++;
      chk_cnt++;
      if ({rdy[3:1], rdy[4], rdy[5], bsy[1], bsy[4]} !== 7'b0001010)
         $display("FAIL b2b_ready got=%b exp=0001010", {rdy[3:1], rdy[4], rdy[5], bsy[1], bsy[4]});
      else pass_cnt++;
      chk_cnt++;
      if (last_data !== 32'h12345678) $display("FAIL b2b_data got=%h exp=12345678", last_data); else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({bus.req_ready, bus.busy} !== 2'b10) $display("FAIL b2b_idle got=%b exp=10", {bus.req_ready, bus.busy}); else pass_cnt++;
   endtask

   initial begin
      chk_cnt = 0; pass_cnt = 0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_MemOp = 3'b010;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_MemOp = 3'b010;
      bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
      test_reset();
      test_aligned_lw();
      test_byte_lane();
      test_misaligned_lw();
      test_misaligned_h();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished (%0d/%0d)", pass_cnt, chk_cnt);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- MEM-stage load/store initiator for the pipelined CPU. It sits between the pipeline and the data memory.
- It accepts one load/store request at a time and drives the data-memory port: `addr` (byte address), `we`, `MemOp`, `datain`, `dataout`.
- It splits misaligned halfword/word accesses into byte beats and assembles and extends load data.
- It returns a one-cycle response, and holds `busy` so the hazard unit stalls the pipeline.

## Interface
- `ADDR_W`, 18: memory byte-address width; `mem_addr` width.
- `SPLIT_MISALIGNED`, 1: 1 = split misaligned accesses into byte beats; 0 = misaligned access returns error, no memory access.
- `clk` input 1: sole clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_MemOp` input 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: qualifies `resp_valid`; set on out-of-range, illegal, or misaligned-with-split-off requests.
- `busy` output 1: high in all states except IDLE.
- `mem_addr` output ADDR_W: byte address to data memory.
- `mem_we` output 1: memory write enable (memory commits on falling edge).
- `mem_MemOp` output 3: access code to memory.
- `mem_datain` output 32: write data to memory.
- `mem_dataout` input 32: memory read data; valid the cycle after the address is presented, with the address held.

## Operation
- **States**
  - IDLE → SETUP on accept (`req_valid & req_ready`), if the request is legal.
  - IDLE → DONE on accept with error.
  - SETUP → XFER always.
  - XFER → SETUP if beats remain, else DONE.
  - DONE → IDLE.
- **Capture on accept:** latch `we`, `MemOp`, `addr[ADDR_W-1:0]`, `wdata`; clear the assembly register; set beat counter k = 0.
- **Error on accept** (no memory cycle, `resp_err=1`) when any of the following holds:
  - `req_addr[31:ADDR_W]` is not 0;
  - load MemOp is 011, 110 or 111;
  - store MemOp is not in {000, 001, 010, 100, 101};
  - the access is misaligned and `SPLIT_MISALIGNED=0`.
- **Store op normalization:** for stores, MemOp bit 2 is forced to 0 before driving (100→000, 101→001).
- **Beat plan:**
  - Aligned access (h with addr[0]=0, w with addr[1:0]=0, any b): N=1 beat, using the original (normalized) MemOp at `addr`.
  - Misaligned h: N=2 byte beats.
  - Misaligned w: N=4 byte beats.
  - Byte beat k uses address (addr+k) mod 2^ADDR_W, so it wraps at the top of memory.
  - Load byte beats use MemOp 100; store byte beats use MemOp 000.
- **SETUP cycle:**
  - `mem_addr` = beat address, `mem_MemOp` = beat code, `mem_we` = 0. This lets the memory latch the target word for its read-modify-write.
- **XFER cycle:**
  - Same `mem_addr` and `mem_MemOp` as SETUP.
  - Store: `mem_we` = 1.
  - Load: sample `mem_dataout` at the closing rising edge.
- **Store data:**
  - Aligned beat: `mem_datain` = `wdata`.
  - Byte beat k: `mem_datain` = {24'h0, wdata[8k+7:8k]}.
- **Load assembly:**
  - Aligned beat: result = `mem_dataout`; the memory already extends.
  - Byte beat k: the byte goes to assembly bits [8k+7:8k].
  - At DONE, the assembled value is extended per the original MemOp: h sign-extends from bit 15, hu zero-extends, w unchanged.
- **DONE:** `resp_valid` = 1 for exactly one cycle with `resp_rdata` / `resp_err`.
- **Idle memory outputs:** outside SETUP/XFER, `mem_we` = 0, `mem_addr` = 0, `mem_MemOp` = 010, `mem_datain` = 0.

## Timing
- **Reset values:** `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_MemOp`=010, `mem_datain`=0, state IDLE.
- **Reset mid-operation:** takes effect immediately. `mem_we` drops asynchronously and no response is issued; a byte-split store may be partially written.
- **Latency:** accept edge E0; SETUP in cycle 1; XFER in cycle 2; `resp_valid` in cycle 2N+1.
  - Aligned: `resp_valid` in cycle 3.
  - Split h: cycle 5.
  - Split w: cycle 9.
  - Error: cycle 1.
- **Throughput:** a new request is accepted no earlier than the cycle after DONE. `req_ready` is 0 from cycle 1 through DONE.
- **Hold rule:** `mem_addr` and `mem_MemOp` are registered outputs, constant across SETUP and XFER of each beat.
- **Request ports:** `req_*` are ignored while `req_ready` = 0. Requests need not be held after acceptance.
- **Port order:** `req_valid` in DONE is not accepted until IDLE.

## Test plan
- **Aligned lw:** preload word 0x40 = 0x8899AABB; lw addr 0x40 → `resp_valid` in cycle 3, `resp_rdata` = 0x8899AABB, `resp_err` = 0, exactly one `mem_we`-free beat.
- **Byte-lane load and store:**
  - lb addr 0x43 → 0xFFFFFF88.
  - lbu addr 0x43 → 0x00000088.
  - sb 0x5A to 0x41, then lw 0x40 → 0x88995ABB.
  - Store MemOp 100 is driven as 000.
- **Misaligned lw:** words 0x40 = 0x44332211 and 0x44 = 0x88776655; lw addr 0x42 → 4 beats at 0x42..0x45, `resp_valid` in cycle 9, data 0x66554433.
- **Misaligned sh and lh:**
  - sh 0xBEEF to 0x47 → bytes 0x47 = 0xEF, 0x48 = 0xBE.
  - lh 0x47 → 0xFFFFBEEF.
  - lhu 0x47 → 0x0000BEEF.
  - Also run split lw at 0x3FFFE: beat addresses wrap 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- **Errors:**
  - Addr 0x00040000 → `resp_err` = 1 in cycle 1, no `mem_we`.
  - Load MemOp 111 → `resp_err` = 1.
  - With `SPLIT_MISALIGNED`=0, lw 0x42 → `resp_err` = 1.
- **Reset and back-to-back:**
  - Assert `rst` during XFER of beat 2 of a split store → outputs reach reset values immediately, no `resp_valid`, and the next request completes normally.
  - Back-to-back `req_valid` is accepted only when `req_ready` = 1.
